alu_cmd_driver: RTL and testbench

//  Initiator side of the ALU interface (clk, vld, opcode, a, b -> out, opVld).

---
 rtl/alu_drv_pkg.sv | 44 ++++
 rtl/alu_drv_fifo.sv | 52 +++++
 rtl/alu_cmd_driver.sv | 180 ++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_drv_pkg.sv
// Shared definitions for the ALU command driver.
//   alu_op_e        : ALU opcode encoding (0 and 7 are illegal)
//   is_legal_op()   : true for opcodes the ALU accepts
//   alu_expected()  : reference result used by the optional result checker
//                     (ALU_DRV_CHECK_EN); computed at MODEL_W bits, callers
//                     keep the low DATA_W bits so any DATA_W <= MODEL_W works.
package alu_drv_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned MODEL_W = 64;

  typedef enum logic [OP_W-1:0] {
    OP_ILL0 = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_OR   = 3'd3,
    OP_AND  = 3'd4,
    OP_XOR  = 3'd5,
    OP_NOT  = 3'd6,
    OP_ILL7 = 3'd7
  } alu_op_e;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op != OP_ILL0) && (op != OP_ILL7);
  endfunction

  function automatic logic [MODEL_W-1:0] alu_expected(input logic [OP_W-1:0] op,
                                                     input logic [MODEL_W-1:0] a,
                                                     input logic [MODEL_W-1:0] b);
    logic [MODEL_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_drv_fifo.sv
// Parameterised synchronous FIFO, async active-low reset of the pointers.
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_push, i_data   : write strobe and data (ignored when full)
//   i_pop            : read strobe (ignored when empty)
//   o_data           : head entry (undefined when empty; caller gates it)
//   o_full, o_empty  : occupancy flags
// DEPTH must be a power of two >= 2.
module alu_drv_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the ALU interface: buffers tagged commands, issues at most
// one ALU operation per cycle under a response-FIFO credit limit, captures
// each result one cycle after issue and returns responses in order.
//   clk, reset                      : clock, asynchronous active-low reset
//   cmd_valid/ready/opcode/a/b      : command stream in
//   alu_vld/opcode/a/b              : registered drive to the ALU
//   alu_out, alu_opvld              : ALU result (latency 1); opVld is unused
//   rsp_valid/ready/data/tag/err/mismatch : response stream out
// Optional macro ALU_DRV_CHECK_EN: compare each captured result against an
// internal model and flag rsp_mismatch; otherwise rsp_mismatch is 0.
module alu_cmd_driver
  import alu_drv_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned TAG_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              alu_vld,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_opvld,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              rsp_mismatch
);

  typedef struct packed {
    logic [2:0]        opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              err;
    logic              mismatch;
  } rsp_t;

  localparam int unsigned CMD_W = $bits(cmd_t);
  localparam int unsigned RSP_W = $bits(rsp_t);
  localparam int unsigned CRD_W = $clog2(RSP_DEPTH + 1);

  cmd_t             w_cmd_in, w_cmd_head;
  rsp_t             w_rsp_in, w_rsp_head, w_rsp_out;
  logic             w_cmd_full, w_cmd_empty, w_rsp_full, w_rsp_empty;
  logic             w_accept, w_issue, w_head_legal, w_rsp_push, w_rsp_pop;
  logic [TAG_W-1:0] r_tag;
  logic [CRD_W-1:0] r_credits;
  logic             r_alu_vld;
  logic [2:0]       r_alu_opcode;
  logic [DATA_W-1:0] r_alu_a, r_alu_b;
  logic             r_p1_vld, r_p1_err, r_p2_vld, r_p2_err;
  logic [TAG_W-1:0] r_p1_tag, r_p2_tag;
  // opVld is sticky, so it carries no per-result timing; capture relies on
  // the fixed one-cycle ALU latency instead.
  logic             w_unused_opvld;

  assign w_unused_opvld = alu_opvld;

  assign cmd_ready    = !w_cmd_full;
  assign w_accept     = cmd_valid && !w_cmd_full;
  assign w_cmd_in     = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, tag: r_tag};
  assign w_head_legal = is_legal_op(w_cmd_head.opcode);
  assign w_issue      = !w_cmd_empty && (r_credits != '0);

  alu_drv_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_accept),
    .i_data  (w_cmd_in),
    .i_pop   (w_issue),
    .o_data  (w_cmd_head),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty)
  );

`ifdef ALU_DRV_CHECK_EN
  logic [MODEL_W-1:0] w_exp_full;
  logic [DATA_W-1:0]  r_p1_exp, r_p2_exp;

  assign w_exp_full = alu_expected(w_cmd_head.opcode, MODEL_W'(w_cmd_head.a),
                                   MODEL_W'(w_cmd_head.b));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p1_exp <= '0;
      r_p2_exp <= '0;
    end else begin
      r_p1_exp <= w_exp_full[DATA_W-1:0];
      r_p2_exp <= r_p1_exp;
    end
  end

  assign w_rsp_in.mismatch = !r_p2_err && (alu_out != r_p2_exp);
`else
  assign w_rsp_in.mismatch = 1'b0;
`endif

  // Stage 1 lines up with alu_vld, stage 2 with the registered alu_out.
  assign w_rsp_in.data = r_p2_err ? '0 : alu_out;
  assign w_rsp_in.tag  = r_p2_tag;
  assign w_rsp_in.err  = r_p2_err;
  assign w_rsp_push    = r_p2_vld && !w_rsp_full;
  assign w_rsp_pop     = !w_rsp_empty && rsp_ready;

  alu_drv_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_rsp_push),
    .i_data  (w_rsp_in),
    .i_pop   (w_rsp_pop),
    .o_data  (w_rsp_head),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag        <= '0;
      r_credits    <= CRD_W'(RSP_DEPTH);
      r_alu_vld    <= 1'b0;
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_p1_vld     <= 1'b0;
      r_p1_err     <= 1'b0;
      r_p1_tag     <= '0;
      r_p2_vld     <= 1'b0;
      r_p2_err     <= 1'b0;
      r_p2_tag     <= '0;
    end else begin
      if (w_accept) r_tag <= r_tag + 1'b1;
      case ({w_issue, w_rsp_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
      r_alu_vld <= w_issue && w_head_legal;
      if (w_issue && w_head_legal) begin
        r_alu_opcode <= w_cmd_head.opcode;
        r_alu_a      <= w_cmd_head.a;
        r_alu_b      <= w_cmd_head.b;
      end
      r_p1_vld <= w_issue;
      r_p1_err <= !w_head_legal;
      r_p1_tag <= w_cmd_head.tag;
      r_p2_vld <= r_p1_vld;
      r_p2_err <= r_p1_err;
      r_p2_tag <= r_p1_tag;
    end
  end

  assign alu_vld    = r_alu_vld;
  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;

  assign w_rsp_out    = w_rsp_empty ? '0 : w_rsp_head;
  assign rsp_valid    = !w_rsp_empty;
  assign rsp_data     = w_rsp_out.data;
  assign rsp_tag      = w_rsp_out.tag;
  assign rsp_err      = w_rsp_out.err;
  assign rsp_mismatch = w_rsp_out.mismatch;

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

`ifdef ALU_DRV_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  localparam logic [15:0] CORRUPT_A = 16'hDEAD;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [15:0] cmd_a, cmd_b;
  logic        alu_vld;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_out = '0;
  logic        alu_opvld = 1'b0;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err, rsp_mismatch;

  alu_cmd_driver #(.DATA_W(16), .CMD_DEPTH(4), .RSP_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_vld(alu_vld), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_opvld(alu_opvld),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .rsp_mismatch(rsp_mismatch)
  );

  initial forever #5 clk = ~clk;

  // External ALU: registers its result when vld; a == CORRUPT_A flips bit 0.
  always @(posedge clk) begin
    if (alu_vld) begin
      case (alu_opcode)
        3'd1: alu_out <= (alu_a + alu_b) ^ {15'd0, alu_a == CORRUPT_A};
        3'd2: alu_out <= (alu_a - alu_b) ^ {15'd0, alu_a == CORRUPT_A};
        3'd3: alu_out <= (alu_a | alu_b) ^ {15'd0, alu_a == CORRUPT_A};
        3'd4: alu_out <= (alu_a & alu_b) ^ {15'd0, alu_a == CORRUPT_A};
        3'd5: alu_out <= (alu_a ^ alu_b) ^ {15'd0, alu_a == CORRUPT_A};
        3'd6: alu_out <= (~alu_a) ^ {15'd0, alu_a == CORRUPT_A};
        default: alu_out <= alu_out;
      endcase
      alu_opvld <= 1'b1;
    end
  end

  typedef struct {
    logic [15:0] data;
    logic [3:0]  tag;
    logic        err;
    logic        mm;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned vld_cnt = 0;
  int unsigned model_tag = 0;
  bit          rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: arithmetic on integers reduced modulo 2^16.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input int unsigned tag);
    exp_t e;
    int unsigned ai, bi, r;
    ai = a; bi = b; r = 0;
    e.tag = 4'(tag % 16);
    e.err = (op == 3'd0) || (op == 3'd7);
    e.mm  = 1'b0;
    case (op)
      3'd1: r = (ai + bi) % 65536;
      3'd2: r = (ai + 65536 - bi) % 65536;
      3'd3: r = ai | bi;
      3'd4: r = ai & bi;
      3'd5: r = ai ^ bi;
      3'd6: r = 65535 - ai;
      default: r = 0;
    endcase
    if (!e.err && a == CORRUPT_A) begin
      r = r ^ 1;
      e.mm = CHECK;
    end
    e.data = 16'(r);
    return e;
  endfunction

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (reset) begin
      if (alu_vld) begin
        vld_cnt++;
        chk("alu_vld_legal_op", 32'(alu_opcode != 3'd0 && alu_opcode != 3'd7), 32'd1);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got data=%0h tag=%0d expected none", rsp_data, rsp_tag);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
          chk("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          chk("rsp_mismatch", 32'(rsp_mismatch), 32'(mon_e.mm));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #3;
      if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: got ready=0 expected 1");
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(op, a, b, model_tag));
    model_tag = (model_tag + 1) % 16;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_alu_vld"}, 32'(alu_vld), 0);
    chk({p, "_alu_opcode"}, 32'(alu_opcode), 0);
    chk({p, "_alu_a"}, 32'(alu_a), 0);
    chk({p, "_alu_b"}, 32'(alu_b), 0);
    chk({p, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({p, "_rsp_data"}, 32'(rsp_data), 0);
    chk({p, "_rsp_tag"}, 32'(rsp_tag), 0);
    chk({p, "_rsp_err"}, 32'(rsp_err), 0);
    chk({p, "_rsp_mismatch"}, 32'(rsp_mismatch), 0);
  endtask

  task automatic do_reset(input string p);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk_zero(p);
    exp_q.delete();
    model_tag = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk({p, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int unsigned v0, lat;
    logic [2:0]  op;
    logic [15:0] a, b;
    reset = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

    // add 3+5, one alu_vld pulse, latency at least 3 cycles
    v0 = vld_cnt;
    send(3'd1, 16'd3, 16'd5);
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("latency_ge3", 32'(lat >= 3 && lat < 50), 32'd1);
    drain();
    chk("add_vld_pulses", vld_cnt - v0, 32'd1);

    // sub wrap and not
    send(3'd2, 16'd0, 16'd1);
    send(3'd6, 16'h00FF, 16'h1234);
    drain();

    // illegal opcode: no ALU drive
    v0 = vld_cnt;
    send(3'd7, 16'd1, 16'd1);
    send(3'd0, 16'd2, 16'd2);
    drain();
    chk("illegal_no_vld", vld_cnt - v0, 32'd0);

    // credit limit with stalled responses
    do_reset("rst2");
    rsp_ready = 1'b0;
    v0 = vld_cnt;
    for (int i = 0; i < 8; i++) send(3'd1, 16'(i), 16'd100);
    repeat (10) @(negedge clk);
    chk("stall_vld_pulses", vld_cnt - v0, 32'd4);
    chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    drain();
    chk("release_vld_pulses", vld_cnt - v0, 32'd8);

    // tag wrap over 17 commands
    for (int i = 0; i < 17; i++) send(3'd5, 16'($urandom), 16'($urandom));
    drain();

    // reset in the middle of traffic; nothing stale afterwards
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(3'd3, 16'($urandom), 16'($urandom));
    do_reset("midrst");
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    send(3'd4, 16'hF0F0, 16'h3C3C);
    send(3'd1, 16'hFFFF, 16'd1);
    drain();

    // corrupted ALU result on one entry only
    send(3'd1, CORRUPT_A, 16'd1);
    send(3'd1, 16'd2, 16'd2);
    send(3'd7, CORRUPT_A, 16'd0);
    drain();

    // randomized traffic with random backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (a == CORRUPT_A) a = 16'h0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(op, a, b);
    end
    rnd_ready = 1'b0;
    rsp_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
